// File: rtl/matrix_store_stream_pkg.sv
// Shared types and helpers for the matrix store: write FSM states, shape
// indexing/legality and derived-width helpers.
package matrix_store_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT} wr_state_e;

  // Derived widths, usable in parameter/localparam expressions
  function automatic int idx_w(input int slots);
    return $clog2(slots);
  endfunction

  function automatic int cnt_w(input int slots);
    return $clog2(slots + 1);
  endfunction

  function automatic int sh_w(input int max_dim);
    return (max_dim * max_dim > 1) ? $clog2(max_dim * max_dim) : 1;
  endfunction

  function automatic logic shape_legal(input logic [7:0] rows, input logic [7:0] cols,
                                       input int max_dim);
    return (rows != 8'd0) && (int'(rows) <= max_dim) &&
           (cols != 8'd0) && (int'(cols) <= max_dim);
  endfunction

  function automatic int shape_idx(input logic [7:0] rows, input logic [7:0] cols,
                                   input int max_dim);
    return (int'(rows) - 1) * max_dim + int'(cols) - 1;
  endfunction

endpackage

// File: rtl/matrix_store_stream_if.sv
// Write stream, read/clear request and read response bundle of the matrix store.
interface matrix_store_stream_if #(
  parameter int MAX_DIM = 5,
  parameter int SLOTS   = 5,
  parameter int EW      = 8
);
  import matrix_store_pkg::*;

  localparam int NELEM = MAX_DIM * MAX_DIM;
  localparam int IDXW  = idx_w(SLOTS);
  localparam int CNTW  = cnt_w(SLOTS);

  logic                  wr_start;
  logic [7:0]            wr_rows;
  logic [7:0]            wr_cols;
  logic                  in_valid;
  logic [EW-1:0]         in_data;
  logic                  in_ready;
  logic                  wr_busy;
  logic                  wr_done;
  logic                  wr_err;
  logic                  wr_abort;
  logic                  clr_req;
  logic                  rd_req;
  logic [7:0]            rd_rows;
  logic [7:0]            rd_cols;
  logic [IDXW-1:0]       rd_idx;
  logic                  rd_valid;
  logic                  rd_hit;
  logic [NELEM*EW-1:0]   rd_data;
  logic [CNTW-1:0]       rd_count;

  modport master (
    output wr_start, wr_rows, wr_cols, in_valid, in_data, wr_abort,
           clr_req, rd_req, rd_rows, rd_cols, rd_idx,
    input  in_ready, wr_busy, wr_done, wr_err, rd_valid, rd_hit, rd_data, rd_count
  );

  modport slave (
    input  wr_start, wr_rows, wr_cols, in_valid, in_data, wr_abort,
           clr_req, rd_req, rd_rows, rd_cols, rd_idx,
    output in_ready, wr_busy, wr_done, wr_err, rd_valid, rd_hit, rd_data, rd_count
  );

endinterface

// File: rtl/matrix_store_stream_slot_ring.sv
// Per-shape circular buffer bookkeeping: write pointer, saturating fill count
// and translation of a read age into a physical slot number.
module matrix_slot_ring
  import matrix_store_pkg::*;
#(
  parameter int SLOTS = 5,
  parameter int IDXW  = idx_w(SLOTS),
  parameter int CNTW  = cnt_w(SLOTS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_commit,
  input  logic            i_clear,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic [IDXW-1:0] o_ptr,
  output logic [CNTW-1:0] o_count,
  output logic [IDXW-1:0] o_rd_slot
);

  localparam int TW = IDXW + 3;

  logic [IDXW-1:0] r_ptr;
  logic [CNTW-1:0] r_count;
  logic [TW-1:0]   w_t0;
  logic [TW-1:0]   w_t1;

  // A clear in the same cycle as a commit wins: the new matrix is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_commit) begin
      r_ptr <= (r_ptr == IDXW'(SLOTS - 1)) ? '0 : r_ptr + IDXW'(1);
      if (r_count != CNTW'(SLOTS)) r_count <= r_count + CNTW'(1);
    end
  end

  // (ptr - 1 - idx) mod SLOTS, biased by 2*SLOTS so idx values past SLOTS stay positive
  always_comb begin
    w_t0 = TW'(r_ptr) + TW'(2 * SLOTS - 1) - TW'(i_rd_idx);
    if (w_t0 >= TW'(2 * SLOTS))  w_t1 = w_t0 - TW'(2 * SLOTS);
    else if (w_t0 >= TW'(SLOTS)) w_t1 = w_t0 - TW'(SLOTS);
    else                         w_t1 = w_t0;
  end

  assign o_ptr     = r_ptr;
  assign o_count   = r_count;
  assign o_rd_slot = IDXW'(w_t1);

endmodule

// File: rtl/matrix_store_stream.sv
// Matrix store: element-serial staged writes committed into per-shape
// circular buffers, age-indexed flattened reads, per-shape clear.
module matrix_store_stream
  import matrix_store_pkg::*;
#(
  parameter int MAX_DIM = 5,
  parameter int SLOTS   = 5,
  parameter int EW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  matrix_store_stream_if.slave bus
);

  localparam int NSHAPE = MAX_DIM * MAX_DIM;
  localparam int NELEM  = MAX_DIM * MAX_DIM;
  localparam int IDXW   = idx_w(SLOTS);
  localparam int CNTW   = cnt_w(SLOTS);
  localparam int SHW    = sh_w(MAX_DIM);
  localparam int ECW    = $clog2(NELEM + 1);
  localparam int AW     = $clog2(NSHAPE * SLOTS);
  localparam int MW     = NELEM * EW;

  wr_state_e r_state, w_next;

  logic [SHW-1:0]             r_shape;
  logic [ECW-1:0]             r_elem_cnt;
  logic [ECW-1:0]             r_nelem;
  logic [NELEM-1:0][EW-1:0]   r_stage;
  logic [MW-1:0]              r_mem [NSHAPE*SLOTS];

  logic                       r_wr_done, r_wr_err, r_rd_valid, r_rd_hit;
  logic [MW-1:0]              r_rd_data;
  logic [CNTW-1:0]            r_rd_count;

  logic                       w_wr_legal, w_rd_legal, w_beat, w_last, w_rd_hit;
  logic [SHW-1:0]             w_wr_sh, w_rd_sh;
  logic [NSHAPE-1:0]          w_commit, w_clear;
  logic [IDXW-1:0]            w_ptr  [NSHAPE];
  logic [IDXW-1:0]            w_slot [NSHAPE];
  logic [CNTW-1:0]            w_cnt  [NSHAPE];
  logic [AW-1:0]              w_wr_addr, w_rd_addr;
  logic [MW-1:0]              w_commit_data;

  assign w_wr_legal = shape_legal(bus.wr_rows, bus.wr_cols, MAX_DIM);
  assign w_rd_legal = shape_legal(bus.rd_rows, bus.rd_cols, MAX_DIM);
  assign w_wr_sh    = w_wr_legal ? SHW'(shape_idx(bus.wr_rows, bus.wr_cols, MAX_DIM)) : '0;
  assign w_rd_sh    = w_rd_legal ? SHW'(shape_idx(bus.rd_rows, bus.rd_cols, MAX_DIM)) : '0;
  assign w_beat     = (r_state == ST_LOAD) && bus.in_valid;
  assign w_last     = w_beat && ((r_elem_cnt + ECW'(1)) == r_nelem);
  assign w_rd_hit   = w_rd_legal && (CNTW'(bus.rd_idx) < w_cnt[w_rd_sh]);
  assign w_wr_addr  = AW'(int'(r_shape) * SLOTS + int'(w_ptr[r_shape]));
  assign w_rd_addr  = AW'(int'(w_rd_sh) * SLOTS + int'(w_slot[w_rd_sh]));

  for (genvar s = 0; s < NSHAPE; s++) begin : g_ring
    assign w_commit[s] = (r_state == ST_COMMIT) && (r_shape == SHW'(s));
    assign w_clear[s]  = bus.clr_req && w_rd_legal && (w_rd_sh == SHW'(s));
    matrix_slot_ring #(.SLOTS(SLOTS)) u_ring (
      .clk       (clk),
      .rst       (rst),
      .i_commit  (w_commit[s]),
      .i_clear   (w_clear[s]),
      .i_rd_idx  (bus.rd_idx),
      .o_ptr     (w_ptr[s]),
      .o_count   (w_cnt[s]),
      .o_rd_slot (w_slot[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.wr_start && w_wr_legal) w_next = ST_LOAD;
      ST_LOAD:   if (bus.wr_abort)               w_next = ST_IDLE;
                 else if (w_last)                w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shape    <= '0;
      r_elem_cnt <= '0;
      r_nelem    <= '0;
      r_stage    <= '0;
      r_wr_done  <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_done <= (r_state == ST_COMMIT);
      r_wr_err  <= bus.wr_start && ((r_state != ST_IDLE) || !w_wr_legal);
      if ((r_state == ST_IDLE) && bus.wr_start && w_wr_legal) begin
        r_shape    <= w_wr_sh;
        r_elem_cnt <= '0;
        r_nelem    <= ECW'(int'(bus.wr_rows) * int'(bus.wr_cols));
      end
      if (w_beat) begin
        for (int k = 0; k < NELEM; k++)
          if (r_elem_cnt == ECW'(k)) r_stage[k] <= bus.in_data;
        r_elem_cnt <= r_elem_cnt + ECW'(1);
      end
    end
  end

  // Staging entries past rows*cols may hold a previous matrix; they commit as 0
  always_comb begin
    w_commit_data = '0;
    for (int k = 0; k < NELEM; k++)
      if (ECW'(k) < r_nelem) w_commit_data[k*EW +: EW] = r_stage[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSHAPE * SLOTS; i++) r_mem[i] <= '0;
    end else if (r_state == ST_COMMIT) begin
      r_mem[w_wr_addr] <= w_commit_data;
    end
  end

  // Reads sample pointers/counts before any same-cycle commit or clear lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_count <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      r_rd_count <= w_rd_legal ? w_cnt[w_rd_sh] : '0;
      if (bus.rd_req) begin
        r_rd_hit  <= w_rd_hit;
        r_rd_data <= w_rd_hit ? r_mem[w_rd_addr] : '0;
      end
    end
  end

  assign bus.in_ready = (r_state == ST_LOAD);
  assign bus.wr_busy  = (r_state != ST_IDLE);
  assign bus.wr_done  = r_wr_done;
  assign bus.wr_err   = r_wr_err;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_hit   = r_rd_hit;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_count = r_rd_count;

endmodule

// File: tb/tb_matrix_store_stream.sv
// Randomized bench for matrix_store_stream against an age-ordered list model
// of the per-shape store.
module tb_matrix_store_stream;
  import matrix_store_pkg::*;

  localparam int MAX_DIM = 5;
  localparam int SLOTS   = 5;
  localparam int EW      = 8;
  localparam int NELEM   = MAX_DIM * MAX_DIM;
  localparam int NSHAPE  = MAX_DIM * MAX_DIM;
  localparam int MW      = NELEM * EW;
  localparam int IDXW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_store_stream_if #(.MAX_DIM(MAX_DIM), .SLOTS(SLOTS), .EW(EW)) bus();

  matrix_store_stream #(.MAX_DIM(MAX_DIM), .SLOTS(SLOTS), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: per shape, newest matrix at index 0, plus number of live entries
  logic [MW-1:0] m_data [NSHAPE][SLOTS];
  int            m_cnt  [NSHAPE];
  int            wdata  [NELEM];

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(input int r, input int c);
    return (r >= 1) && (r <= MAX_DIM) && (c >= 1) && (c <= MAX_DIM);
  endfunction

  function automatic int m_sh(input int r, input int c);
    return (r - 1) * MAX_DIM + (c - 1);
  endfunction

  task automatic m_reset();
    for (int s = 0; s < NSHAPE; s++) begin
      m_cnt[s] = 0;
      for (int i = 0; i < SLOTS; i++) m_data[s][i] = '0;
    end
  endtask

  task automatic m_commit(input int s, input logic [MW-1:0] d);
    for (int i = SLOTS - 1; i > 0; i--) m_data[s][i] = m_data[s][i-1];
    m_data[s][0] = d;
    if (m_cnt[s] < SLOTS) m_cnt[s]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_wdata();
    for (int i = 0; i < NELEM; i++) wdata[i] = int'($urandom_range(0, 255));
  endtask

  // stall: idle cycles between beats (-1 random 0..2); err_at: beat carrying a
  // stray wr_start; abort_at: beat index replaced by wr_abort; clr: clear on commit
  task automatic do_write(input int r, input int c, input int stall, input int err_at,
                          input int abort_at, input bit clr);
    logic [MW-1:0] mat;
    int n;
    mat = '0;
    n = r * c;
    bus.wr_start = 1'b1; bus.wr_rows = 8'(r); bus.wr_cols = 8'(c);
    tick();
    bus.wr_start = 1'b0;
    chk("wr_err_legal", MW'(bus.wr_err), MW'(0));
    chk("in_ready_load", MW'(bus.in_ready), MW'(1));
    for (int b = 0; b < n; b++) begin
      int gap;
      gap = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      if (b == abort_at) begin
        bus.wr_abort = 1'b1;
        tick();
        bus.wr_abort = 1'b0;
        chk("abort_idle", MW'(bus.wr_busy), MW'(0));
        tick();
        chk("abort_no_done", MW'(bus.wr_done), MW'(0));
        return;
      end
      for (int g = 0; g < gap && b > 0; g++) begin
        bus.in_data = EW'($urandom);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = EW'(wdata[b]);
      mat[b*EW +: EW] = EW'(wdata[b]);
      if (b == err_at) begin
        bus.wr_start = 1'b1; bus.wr_rows = 8'd1; bus.wr_cols = 8'd1;
      end
      tick();
      bus.in_valid = 1'b0;
      bus.wr_start = 1'b0;
      if (b == err_at) chk("wr_err_busy", MW'(bus.wr_err), MW'(1));
    end
    chk("in_ready_drop", MW'(bus.in_ready), MW'(0));
    chk("busy_commit", MW'(bus.wr_busy), MW'(1));
    chk("done_early", MW'(bus.wr_done), MW'(0));
    if (clr) begin
      bus.clr_req = 1'b1; bus.rd_rows = 8'(r); bus.rd_cols = 8'(c);
    end
    tick();
    bus.clr_req = 1'b0;
    chk("wr_done", MW'(bus.wr_done), MW'(1));
    m_commit(m_sh(r, c), mat);
    if (clr) m_cnt[m_sh(r, c)] = 0;
  endtask

  task automatic bad_start(input int r, input int c);
    bus.wr_start = 1'b1; bus.wr_rows = 8'(r); bus.wr_cols = 8'(c);
    tick();
    bus.wr_start = 1'b0;
    chk("wr_err_illegal", MW'(bus.wr_err), MW'(1));
    chk("illegal_in_ready", MW'(bus.in_ready), MW'(0));
    chk("illegal_busy", MW'(bus.wr_busy), MW'(0));
    tick();
    chk("wr_err_pulse", MW'(bus.wr_err), MW'(0));
  endtask

  task automatic do_read(input int r, input int c, input int idx);
    bit            hit;
    logic [MW-1:0] d;
    int            cnt;
    cnt = m_legal(r, c) ? m_cnt[m_sh(r, c)] : 0;
    hit = m_legal(r, c) && (idx < cnt);
    d   = hit ? m_data[m_sh(r, c)][idx] : '0;
    bus.rd_req = 1'b1; bus.rd_rows = 8'(r); bus.rd_cols = 8'(c); bus.rd_idx = IDXW'(idx);
    tick();
    bus.rd_req = 1'b0;
    chk("rd_valid", MW'(bus.rd_valid), MW'(1));
    chk("rd_hit", MW'(bus.rd_hit), MW'(hit));
    chk("rd_data", bus.rd_data, d);
    chk("rd_count", MW'(bus.rd_count), MW'(cnt));
    tick();
    chk("rd_valid_pulse", MW'(bus.rd_valid), MW'(0));
    chk("rd_data_hold", bus.rd_data, d);
  endtask

  task automatic do_clear(input int r, input int c);
    bus.clr_req = 1'b1; bus.rd_rows = 8'(r); bus.rd_cols = 8'(c);
    tick();
    bus.clr_req = 1'b0;
    if (m_legal(r, c)) m_cnt[m_sh(r, c)] = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, MW'(bus.in_ready), MW'(0));
    chk({tag, "_wr_busy"},  MW'(bus.wr_busy),  MW'(0));
    chk({tag, "_wr_done"},  MW'(bus.wr_done),  MW'(0));
    chk({tag, "_wr_err"},   MW'(bus.wr_err),   MW'(0));
    chk({tag, "_rd_valid"}, MW'(bus.rd_valid), MW'(0));
    chk({tag, "_rd_hit"},   MW'(bus.rd_hit),   MW'(0));
    chk({tag, "_rd_data"},  bus.rd_data,       MW'(0));
    chk({tag, "_rd_count"}, MW'(bus.rd_count), MW'(0));
  endtask

  function automatic int rand_dim();
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 0) ? 0 : 6;
    return int'($urandom_range(1, 5));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.wr_start = 1'b0; bus.wr_rows = 8'd0; bus.wr_cols = 8'd0;
    bus.in_valid = 1'b0; bus.in_data = '0;   bus.wr_abort = 1'b0;
    bus.clr_req  = 1'b0; bus.rd_req  = 1'b0;
    bus.rd_rows  = 8'd0; bus.rd_cols = 8'd0; bus.rd_idx   = '0;
    m_reset();
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 2x3 {1..6}
    for (int i = 0; i < NELEM; i++) wdata[i] = i + 1;
    do_write(2, 3, 0, -1, -1, 1'b0);
    do_read(2, 3, 0);

    // 1x1 ring: miss past fill level, then wrap after 7 writes
    for (int v = 10; v < 13; v++) begin
      wdata[0] = v;
      do_write(1, 1, 0, -1, -1, 1'b0);
    end
    do_read(1, 1, 4);
    for (int v = 13; v < 17; v++) begin
      wdata[0] = v;
      do_write(1, 1, 0, -1, -1, 1'b0);
    end
    for (int i = 0; i < 6; i++) do_read(1, 1, i);

    // Illegal dims and wr_start while busy
    bad_start(6, 1);
    bad_start(0, 3);
    rand_wdata();
    do_write(2, 2, 0, 1, -1, 1'b0);
    do_read(2, 2, 0);
    do_read(1, 1, 0);

    // Abort after 4 beats leaves the earlier 3x3 intact
    rand_wdata();
    do_write(3, 3, 0, -1, -1, 1'b0);
    rand_wdata();
    do_write(3, 3, 0, -1, 4, 1'b0);
    do_read(3, 3, 0);

    // Stalled stream 1,0,0,1,...
    rand_wdata();
    do_write(2, 2, 2, -1, -1, 1'b0);
    do_read(2, 2, 0);
    do_read(2, 2, 1);

    // Clear in the commit cycle of the same shape
    rand_wdata();
    do_write(2, 2, 0, -1, -1, 1'b1);
    do_read(2, 2, 0);

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      int op, r, c;
      op = int'($urandom_range(0, 9));
      r  = rand_dim();
      c  = rand_dim();
      if (op < 4) begin
        if (m_legal(r, c)) begin
          int ab;
          ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, r * c - 1)) : -1;
          rand_wdata();
          do_write(r, c, -1, -1, ab, ($urandom_range(0, 9) == 0));
        end else begin
          bad_start(r, c);
        end
      end else if (op < 9) begin
        do_read(r, c, int'($urandom_range(0, 6)));
      end else begin
        do_clear(r, c);
      end
    end

    // Asynchronous reset in the middle of a load
    bus.wr_start = 1'b1; bus.wr_rows = 8'd3; bus.wr_cols = 8'd2;
    tick();
    bus.wr_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1; bus.in_data = EW'($urandom);
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("midload_rst");
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    m_reset();
    tick();
    chk("post_rst_in_ready", MW'(bus.in_ready), MW'(0));
    do_read(2, 3, 0);
    do_read(1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
